// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types (mode, FSM state, march phase) and the expected-data pattern function
package mem_bist_pkg;
  localparam int MAX_DW = 64;
  typedef enum logic [1:0] {CLEAR, DATA_EQ_ADDR, CHECKERBOARD, MARCH} mode_e;
  typedef enum logic [2:0] {IDLE, WR_PHASE, RD_REQ, RD_WAIT, MARCH_RW, DONE} state_e;
  typedef enum logic [1:0] {PH_W0, PH_R0W1, PH_R1} phase_e;
  function automatic logic [MAX_DW-1:0] pattern(mode_e m, phase_e p, logic [31:0] a);
    logic [MAX_DW-1:0] cb;
    cb = {(MAX_DW/2){2'b01}};
    return m == CLEAR ? {MAX_DW{1'b0}} :
           m == DATA_EQ_ADDR ? MAX_DW'(a) :
           m == CHECKERBOARD ? (a[0] ? ~cb : cb) :
           {MAX_DW{p != PH_W0}};
  endfunction
endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: memory pin bundle (read, write, addr, data_in from engine; data_out from memory), master=engine, slave=memory
interface mem_bist_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) ();
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  modport master (output read, write, addr, data_in, input data_out);
  modport slave (input read, write, addr, data_in, output data_out);
endinterface

// File: rtl/mem_bist_addr_gen.sv
// mem_bist_addr_gen: loadable up/down address counter (ld/ld_val load, en step, down direction, addr/nxt value, tc terminal flag)
module mem_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld,
  input  logic                  en,
  input  logic                  down,
  input  logic [ADDR_WIDTH-1:0] ld_val,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] nxt,
  output logic                  tc
);
  assign nxt = down ? addr - 1'b1 : addr + 1'b1;
  assign tc = down ? addr == '0 : &addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr <= '0;
    else addr <= ld ? ld_val : en ? nxt : addr;
endmodule

// File: rtl/mem_bist_engine.sv
// mem_bist_engine: memory BIST (start/mode in; busy/done/pass/err_count/first_err_* status out; memory pins via mem_bist_if.master)
module mem_bist_engine
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     first_err_valid,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  mem_bist_if.master               mem
);
  state_e                state;
  mode_e                 mode_r;
  phase_e                phase;
  logic [1:0]            lat;
  logic [ADDR_WIDTH-1:0] addr, nxt;
  logic                  tc, ld, en, cmp, mis, rw_ph;
  logic [DATA_WIDTH-1:0] exp_rd;
  assign rw_ph = mode_r == MARCH && phase == PH_R0W1;
  assign cmp = state == RD_WAIT && lat == 2'(READ_LATENCY - 1);
  // the R0 read of the R0W1 step still expects the W0 data
  assign exp_rd = DATA_WIDTH'(pattern(mode_r, phase == PH_R0W1 ? PH_W0 : phase, 32'(addr)));
  // case-inequality so X/Z read data is flagged as a mismatch in simulation
  assign mis = mem.data_out !== exp_rd;
  assign ld = (start && (state == IDLE || state == DONE)) || (tc && (state == WR_PHASE || state == MARCH_RW));
  assign en = !tc && (state == WR_PHASE || state == MARCH_RW || (cmp && !rw_ph));
  assign mem.addr = addr;
  mem_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk, .rst_n, .ld, .en,
    .down(phase == PH_R1),
    .ld_val({ADDR_WIDTH{state == MARCH_RW}}),
    .addr, .nxt, .tc
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mode_r <= CLEAR;
      phase <= PH_W0;
      lat <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_valid <= 1'b0;
      first_err_addr <= '0;
      mem.read <= 1'b0;
      mem.write <= 1'b0;
      mem.data_in <= '0;
    end else begin
      if (cmp && mis) begin
        err_count <= &err_count ? err_count : err_count + 1'b1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr <= addr;
        end
      end
      case (state)
        IDLE, DONE: if (start) begin
          state <= WR_PHASE;
          mode_r <= mode_e'(mode);
          phase <= PH_W0;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          err_count <= '0;
          first_err_valid <= 1'b0;
          first_err_addr <= '0;
          mem.write <= 1'b1;
          mem.data_in <= DATA_WIDTH'(pattern(mode_e'(mode), PH_W0, '0));
        end
        WR_PHASE: begin
          mem.write <= !tc;
          mem.read <= tc;
          if (tc) begin
            state <= RD_REQ;
            phase <= mode_r == MARCH ? PH_R0W1 : PH_W0;
          end else mem.data_in <= DATA_WIDTH'(pattern(mode_r, PH_W0, 32'(nxt)));
        end
        RD_REQ: begin
          mem.read <= 1'b0;
          lat <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT:
          if (!cmp) lat <= lat + 1'b1;
          else if (rw_ph) begin
            state <= MARCH_RW;
            mem.write <= 1'b1;
            mem.data_in <= DATA_WIDTH'(pattern(mode_r, PH_R0W1, 32'(addr)));
          end else if (tc) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= !mis && err_count == '0;
          end else begin
            state <= RD_REQ;
            mem.read <= 1'b1;
          end
        MARCH_RW: begin
          mem.write <= 1'b0;
          mem.read <= 1'b1;
          state <= RD_REQ;
          if (tc) phase <= PH_R1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_bist_engine.sv
// tb_mem_bist_engine: directed bench with write scoreboard for two engine configurations (RL=1/ECW=16 and RL=3/ECW=4)
module tb_mem_bist_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic busy_a, done_a, pass_a, fev_a, busy_b, done_b, pass_b, fev_b;
  logic [15:0] err_a;
  logic [3:0] err_b;
  logic [4:0] fea_a, fea_b;
  int n_pass = 0, n_chk = 0, n_fail = 0;
  mem_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) ifa ();
  mem_bist_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) ifb ();
  mem_bist_engine #(.READ_LATENCY(1), .ERR_CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a), .first_err_addr(fea_a), .mem(ifa.master));
  mem_bist_engine #(.READ_LATENCY(3), .ERR_CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_valid(fev_b), .first_err_addr(fea_b), .mem(ifb.master));
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] pb [3];
  logic [4:0] f_addr = '0;
  logic [7:0] f_sa1 = '0, f_sa0 = '0;
  logic inv_b = 1'b0;
  always @(posedge clk) begin
    if (ifa.write) mem_a[ifa.addr] <= ifa.data_in;
    if (ifa.read) ifa.data_out <= ifa.addr == f_addr ? (mem_a[ifa.addr] | f_sa1) & ~f_sa0 : mem_a[ifa.addr];
    if (ifb.write) mem_b[ifb.addr] <= ifb.data_in;
    pb[0] <= ifb.read ? (inv_b ? ~mem_b[ifb.addr] : mem_b[ifb.addr]) : 8'h00;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign ifb.data_out = pb[2];
  logic sel = 1'b0;
  logic busy_s, done_s, pass_s, fev_s, rd_s, wr_s;
  logic [15:0] err_s;
  logic [4:0] fea_s;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign fev_s = sel ? fev_b : fev_a;
  assign fea_s = sel ? fea_b : fea_a;
  assign err_s = sel ? 16'(err_b) : err_a;
  assign rd_s = sel ? ifb.read : ifa.read;
  assign wr_s = sel ? ifb.write : ifa.write;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  logic [14:0] qa[$], qb[$];
  always @(negedge clk) begin
    if (ifa.write) check("wr_a", 64'({ifa.read, ifa.write, ifa.addr, ifa.data_in}), qa.size() > 0 ? 64'(qa.pop_front()) : 64'h1_0000);
    if (ifb.write) check("wr_b", 64'({ifb.read, ifb.write, ifb.addr, ifb.data_in}), qb.size() > 0 ? 64'(qb.pop_front()) : 64'h1_0000);
  end
  function automatic logic [7:0] exp_pat(input logic [1:0] m, input int a);
    return m == 2'd1 ? 8'(a) : m == 2'd2 ? (a % 2 == 1 ? 8'hAA : 8'h55) : 8'h00;
  endfunction
  task automatic push_exp(input bit b, input logic [1:0] m);
    logic [14:0] e;
    for (int p = 0; p < (m == 2'd3 ? 2 : 1); p++)
      for (int a = 0; a < 32; a++) begin
        e = {2'b01, 5'(a), p == 1 ? 8'hFF : exp_pat(m, a)};
        if (b) qb.push_back(e);
        else qa.push_back(e);
      end
  endtask
  task automatic set_start(input bit b, input logic s, input logic [1:0] m);
    if (b) begin start_b = s; mode_b = m; end
    else begin start_a = s; mode_a = m; end
  endtask
  task automatic run(input bit b, input logic [1:0] m, input bit poke, input int exp_busy, input bit exp_pass,
                     input int exp_err, input bit exp_fev, input int exp_fea, input string tag);
    int n;
    sel = b;
    push_exp(b, m);
    @(negedge clk);
    set_start(b, 1'b1, m);
    @(negedge clk);
    set_start(b, 1'b0, m);
    n = 0;
    while (busy_s && n < 1000) begin
      n++;
      if (poke && n == 20) set_start(b, 1'b1, 2'd3);
      else set_start(b, 1'b0, m);
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, "_done"}, 64'(done_s), 64'd1);
    check({tag, "_pass"}, 64'(pass_s), 64'(exp_pass));
    check({tag, "_err_count"}, 64'(err_s), 64'(exp_err));
    check({tag, "_first_err_valid"}, 64'(fev_s), 64'(exp_fev));
    check({tag, "_first_err_addr"}, 64'(fea_s), 64'(exp_fea));
    check({tag, "_strobes_idle"}, 64'({rd_s, wr_s}), 64'd0);
    check({tag, "_writes_left"}, 64'(b ? qb.size() : qa.size()), 64'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_a", 64'({busy_a, done_a, pass_a, err_a, fev_a, fea_a, ifa.read, ifa.write, ifa.addr, ifa.data_in}), 64'd0);
    check("reset_b", 64'({busy_b, done_b, pass_b, err_b, fev_b, fea_b, ifb.read, ifb.write, ifb.addr, ifb.data_in}), 64'd0);
    rst_n = 1'b1;
    run(1'b0, 2'd0, 1'b0, 96, 1'b1, 0, 1'b0, 0, "clear");
    f_addr = 5'd5; f_sa1 = 8'h08;
    run(1'b0, 2'd1, 1'b0, 96, 1'b0, 1, 1'b1, 5, "daddr_sa1");
    f_addr = 5'd31; f_sa1 = 8'h00; f_sa0 = 8'h01;
    run(1'b0, 2'd3, 1'b0, 192, 1'b0, 1, 1'b1, 31, "march_sa0");
    f_sa0 = 8'h00;
    run(1'b1, 2'd2, 1'b0, 160, 1'b1, 0, 1'b0, 0, "checker_rl3");
    inv_b = 1'b1;
    run(1'b1, 2'd1, 1'b0, 160, 1'b0, 15, 1'b1, 0, "saturate");
    inv_b = 1'b0;
    sel = 1'b0;
    push_exp(1'b0, 2'd1);
    @(negedge clk);
    set_start(1'b0, 1'b1, 2'd1);
    @(negedge clk);
    set_start(1'b0, 1'b0, 2'd1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_run", 64'({busy_a, done_a, pass_a, err_a, fev_a, fea_a, ifa.read, ifa.write, ifa.addr, ifa.data_in}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    run(1'b0, 2'd0, 1'b1, 96, 1'b1, 0, 1'b0, 0, "after_reset_poke");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
